// File: rtl/hex_entry_if.sv
// Commit handshake between hex_entry and its consumer.
// master: the producer (hex_entry) drives out_data/out_valid, samples out_ready.
// slave:  the consumer samples out_data/out_valid, drives out_ready.
interface hex_entry_if #(
    parameter int DW = 32
) ();
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/hex_entry.sv
// hex_entry: collects single-cycle hex-key pulses into a word (newest digit in
// the low nibble), supports delete, and commits the word on enter through a
// valid/ready handshake.
// Optional macro HEX_ENTRY_OVF_LOCK_EN: when defined, a digit key on a full
// buffer is rejected and flagged on the extra ovf output. When undefined, the
// oldest digit is shifted out instead and there is no ovf port.
module hex_entry #(
    parameter int DIGITS = 8,
    parameter int CW     = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [15:0]         hd_ps,
    input  logic                ent_ps,
    input  logic                del_ps,
    output logic [4*DIGITS-1:0] buf_data,
    output logic [CW-1:0]       buf_cnt,
    output logic                key_err,
`ifdef HEX_ENTRY_OVF_LOCK_EN
    output logic                ovf,
`endif
    hex_entry_if.master         out_if
);

    typedef enum logic {
        EDIT = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [CW-1:0] FULL = CW'(DIGITS);

    // Bit gi of the key index is set by every key whose number has bit gi set.
    localparam logic [15:0] IDX_MASK [4] = '{16'hAAAA, 16'hCCCC, 16'hF0F0, 16'hFF00};

    state_t              state_reg;
    logic [4*DIGITS-1:0] buf_data_reg;
    logic [CW-1:0]       buf_cnt_reg;
    logic [4*DIGITS-1:0] out_data_reg;
    logic                out_valid_reg;
    logic                key_err_reg;
    logic                ovf_reg;

    logic [3:0]          key_idx;
    logic                key_any;
    logic                key_multi;

    // One-hot to binary encoding of the pressed key (meaningful only for one key).
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_key_enc
            assign key_idx[gi] = |(hd_ps & IDX_MASK[gi]);
        end
    endgenerate

    assign key_any   = |hd_ps;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign key_multi = |(hd_ps & (hd_ps - 16'd1));

    // Edit/hold state machine; all outputs are registered here.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= EDIT;
            buf_data_reg  <= '0;
            buf_cnt_reg   <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            key_err_reg   <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            key_err_reg <= 1'b0;
            ovf_reg     <= 1'b0;
            case (state_reg)
                EDIT: begin
                    if (ent_ps) begin
                        // Commit wins over any key or delete in the same cycle.
                        out_data_reg  <= buf_data_reg;
                        out_valid_reg <= 1'b1;
                        buf_data_reg  <= '0;
                        buf_cnt_reg   <= '0;
                        state_reg     <= HOLD;
                    end else if (del_ps) begin
                        if (buf_cnt_reg != '0) begin
                            buf_data_reg <= buf_data_reg >> 4;
                            buf_cnt_reg  <= buf_cnt_reg - 1'b1;
                        end
                    end else if (key_multi) begin
                        key_err_reg <= 1'b1;
                    end else if (key_any) begin
`ifdef HEX_ENTRY_OVF_LOCK_EN
                        if (buf_cnt_reg == FULL) begin
                            ovf_reg <= 1'b1;
                        end else begin
                            buf_data_reg <= {buf_data_reg[4*DIGITS-5:0], key_idx};
                            buf_cnt_reg  <= buf_cnt_reg + 1'b1;
                        end
`else
                        buf_data_reg <= {buf_data_reg[4*DIGITS-5:0], key_idx};
                        if (buf_cnt_reg != FULL) begin
                            buf_cnt_reg <= buf_cnt_reg + 1'b1;
                        end
`endif
                    end
                end
                HOLD: begin
                    // All key inputs are ignored until the consumer takes the word.
                    if (out_if.out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= EDIT;
                    end
                end
                default: state_reg <= EDIT;
            endcase
        end
    end

    assign buf_data         = buf_data_reg;
    assign buf_cnt          = buf_cnt_reg;
    assign key_err          = key_err_reg;
    assign out_if.out_data  = out_data_reg;
    assign out_if.out_valid = out_valid_reg;
`ifdef HEX_ENTRY_OVF_LOCK_EN
    assign ovf = ovf_reg;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_hex_entry.sv
// Testbench for hex_entry: directed scenarios plus random pulses, checked every
// cycle against a digit-queue reference model.
module tb_hex_entry;
    localparam int DIGITS = 8;
    localparam int CW     = 4;

    logic        clk;
    logic        rstn;
    logic [15:0] hd_ps;
    logic        ent_ps;
    logic        del_ps;
    logic [31:0] buf_data;
    logic [3:0]  buf_cnt;
    logic        key_err;
`ifdef HEX_ENTRY_OVF_LOCK_EN
    logic        ovf;
`endif

    hex_entry_if #(.DW(32)) bus ();

    hex_entry #(.DIGITS(DIGITS), .CW(CW)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .hd_ps    (hd_ps),
        .ent_ps   (ent_ps),
        .del_ps   (del_ps),
        .buf_data (buf_data),
        .buf_cnt  (buf_cnt),
        .key_err  (key_err),
`ifdef HEX_ENTRY_OVF_LOCK_EN
        .ovf      (ovf),
`endif
        .out_if   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: digits as a queue (oldest first), plus commit state.
    int unsigned m_q[$];
    logic        m_hold;
    logic [31:0] m_out;
    logic        m_valid;
    logic        m_err;
    logic        m_ovf;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_pack();
        logic [31:0] v = '0;
        foreach (m_q[i]) v = (v << 4) | 32'(m_q[i]);
        return v;
    endfunction

    task automatic m_reset();
        m_q.delete();
        m_hold = 0; m_out = '0; m_valid = 0; m_err = 0; m_ovf = 0;
    endtask

    task automatic m_update(input logic [15:0] hd, input logic ent, input logic del, input logic rdy);
        int k;
        m_err = 0; m_ovf = 0;
        if (m_hold) begin
            if (rdy) begin m_valid = 0; m_hold = 0; end
        end else if (ent) begin
            m_out = m_pack(); m_valid = 1; m_hold = 1; m_q.delete();
        end else if (del) begin
            if (m_q.size() > 0) void'(m_q.pop_back());
        end else if (hd != 0) begin
            if ($countones(hd) > 1) m_err = 1;
            else begin
                k = 0;
                for (int i = 0; i < 16; i++) if (hd[i]) k = i;
                if (m_q.size() == DIGITS) begin
`ifdef HEX_ENTRY_OVF_LOCK_EN
                    m_ovf = 1;
`else
                    void'(m_q.pop_front());
                    m_q.push_back(k);
`endif
                end else m_q.push_back(k);
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".buf_data"}, 64'(buf_data), 64'(m_pack()));
        check({tag, ".buf_cnt"}, 64'(buf_cnt), 64'(m_q.size()));
        check({tag, ".out_valid"}, 64'(bus.out_valid), 64'(m_valid));
        check({tag, ".out_data"}, 64'(bus.out_data), 64'(m_out));
        check({tag, ".key_err"}, 64'(key_err), 64'(m_err));
`ifdef HEX_ENTRY_OVF_LOCK_EN
        check({tag, ".ovf"}, 64'(ovf), 64'(m_ovf));
`endif
    endtask

    // One clock cycle with the given pulses; model and DUT compared after the edge.
    task automatic step(input string tag, input logic [15:0] hd, input logic ent,
                        input logic del, input logic rdy);
        @(negedge clk);
        hd_ps = hd; ent_ps = ent; del_ps = del; bus.out_ready = rdy;
        @(posedge clk);
        m_update(hd, ent, del, rdy);
        #1;
        compare_all(tag);
        hd_ps = '0; ent_ps = 0; del_ps = 0;
    endtask

    task automatic key(input string tag, input int k);
        step(tag, 16'(1) << k, 0, 0, 0);
    endtask

    initial begin
        logic [15:0] hd;
        logic        ent, del, rdy;
        int unsigned r;

        rstn = 0; hd_ps = '0; ent_ps = 0; del_ps = 0; bus.out_ready = 0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all("reset");
        @(negedge clk);
        rstn = 1;

        // Three digits, then deletes down past empty.
        key("k1", 1); key("k2", 2); key("k3", 3);
        check("seq123", 64'(buf_data), 64'h123);
        step("del1", 0, 0, 1, 0);
        step("del2", 0, 0, 1, 0);
        check("after2del", 64'(buf_data), 64'h1);
        repeat (3) step("del_more", 0, 0, 1, 0);
        check("empty_cnt", 64'(buf_cnt), 64'h0);

        // Commit 0xA5 and hold it with out_ready low; keys ignored in HOLD.
        key("kA", 10); key("k5", 5);
        step("ent_a5", 0, 1, 0, 0);
        check("a5_out", 64'(bus.out_data), 64'hA5);
        for (int i = 0; i < 5; i++) step("hold", (i == 2) ? 16'h0080 : 16'h0, 0, (i == 3), 0);
        step("hs_key", 16'h0100, 0, 0, 1);
        check("hs_valid", 64'(bus.out_valid), 64'h0);
        check("hs_buf", 64'(buf_cnt), 64'h0);

        // Multi-key error, then key together with enter.
        key("k4", 4);
        step("multi", 16'h0011, 0, 0, 0);
        check("multi_err", 64'(key_err), 64'h1);
        step("multi_after", 0, 0, 0, 0);
        step("key_ent", 16'h0200, 1, 0, 0);
        check("key_ent_out", 64'(bus.out_data), 64'h4);
        step("release", 0, 0, 0, 1);

        // Nine digits into an eight-digit buffer.
        for (int i = 1; i <= 9; i++) key("nine", i);
`ifdef HEX_ENTRY_OVF_LOCK_EN
        check("nine_data", 64'(buf_data), 64'h12345678);
`else
        check("nine_data", 64'(buf_data), 64'h23456789);
`endif
        check("nine_cnt", 64'(buf_cnt), 64'h8);

        // Asynchronous reset while holding a committed word.
        step("ent_rst", 0, 1, 0, 0);
        key("hold_k", 3);
        #3;
        rstn = 0;
        #1;
        m_reset();
        check("arst_valid", 64'(bus.out_valid), 64'h0);
        check("arst_out", 64'(bus.out_data), 64'h0);
        check("arst_buf", 64'(buf_data), 64'h0);
        @(negedge clk);
        rstn = 1;
        key("post_k7", 7); key("post_kE", 14);
        step("post_ent", 0, 1, 0, 0);
        check("post_out", 64'(bus.out_data), 64'h7E);
        step("post_rdy", 0, 0, 0, 1);

        // Random pulses.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            hd = '0;
            if (r < 45) hd = 16'(1) << $urandom_range(0, 15);
            else if (r < 52) hd = 16'($urandom()) | 16'h0003;
            ent = ($urandom_range(0, 19) == 0);
            del = ($urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 2) == 0);
            step("rand", hd, ent, del, rdy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
